meas_word_writer: RTL and testbench
===================================

MEAS_WORD_WRITER -- requirements
Module: meas_word_writer

Interface
REQ-001 SHALL have parameter CNT_W, default 23: width of count_p/count_m.
REQ-002 SHALL have parameter WORD_W, default 24: FIFO word width; SHALL equal CNT_W+1.
REQ-003 SHALL have port clk_12mhz, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_sync, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port capture, input, 1 bit: one-cycle strobe from counter marking a completed gate window.
REQ-006 SHALL have port count_p, input, CNT_W: positive-phase count, unsigned.
REQ-007 SHALL have port count_m, input, CNT_W: negative-phase count, unsigned.
REQ-008 SHALL have port count_mode, input, 1 bit: 0 = direct count, 1 = difference.
REQ-009 SHALL have port flush, input, 1 bit: SPI-commanded abort and clear.
REQ-010 SHALL have port fifo_full, input, 1 bit: downstream FIFO full flag.
REQ-011 SHALL have port fifo_data, output, WORD_W: word presented to the FIFO.
REQ-012 SHALL have port fifo_wr_en, output, 1 bit: one-cycle FIFO write strobe.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port drop_cnt, output, 8 bits: count of lost samples, saturating.

Function
REQ-015 FSM states SHALL be IDLE, LATCH, CALC and WRITE.
REQ-016 In IDLE, capture=1 SHALL register count_p, count_m and count_mode, then go to LATCH.
REQ-017 LATCH SHALL go to CALC unconditionally; CALC SHALL register the result and go to WRITE.
REQ-018 Mode 0 result SHALL be {1'b0, count_p}; count_m is ignored.
REQ-019 Mode 1 result SHALL be count_p - count_m as a WORD_W two's-complement value, with no overflow possible.
REQ-020 In WRITE with fifo_full=0, the block SHALL pulse fifo_wr_en for exactly one cycle with the result on fifo_data, then return to IDLE.
REQ-021 In WRITE with fifo_full=1, the block SHALL NOT write, SHALL increment drop_cnt, and SHALL return to IDLE.
REQ-022 Latency: capture in cycle N SHALL produce fifo_wr_en in cycle N+3.
REQ-023 A capture while busy=1 SHALL be discarded and SHALL increment drop_cnt.
REQ-024 A full drop and a busy-capture drop in the same cycle SHALL increment drop_cnt by 2, saturating at 255.
REQ-025 drop_cnt SHALL hold at 255 and never wrap.
REQ-026 flush=1 SHALL, on the next edge, force IDLE, suppress any pending write, and clear drop_cnt.
REQ-027 flush SHALL take priority over a simultaneous capture, which is discarded and not counted.
REQ-028 fifo_data SHALL hold its last value when fifo_wr_en=0.

Reset
REQ-029 rst_sync=1 at an edge SHALL set state=IDLE, fifo_wr_en=0, fifo_data=0, drop_cnt=0, busy=0 and clear the internal latches.
REQ-030 Reset mid-operation SHALL abandon the sample with no write; capture during reset SHALL be ignored.
REQ-031 Reset SHALL take priority over flush.

Configuration
REQ-032 Macro MEAS_SEQ_TAG_EN, when defined, SHALL make fifo_data[23:22] a 2-bit sequence tag and fifo_data[21:0] the saturated result.
REQ-033 With MEAS_SEQ_TAG_EN, the tag SHALL increment mod 4 per successful write only, and reset/flush SHALL clear it to 0.
REQ-034 With MEAS_SEQ_TAG_EN, mode 0 SHALL clamp to 22'h3FFFFF and mode 1 SHALL clamp to the range [-2^21, 2^21-1].
REQ-035 Without MEAS_SEQ_TAG_EN, fifo_data SHALL be the full REQ-018/REQ-019 result with no tag logic present.

Structure
REQ-036 Package meas_pkg SHALL hold the FSM state enum, CNT_W/WORD_W defaults, the tag width (2) and the saturation limits.
REQ-037 Arithmetic and saturation SHALL be one combinational sub-module, meas_word_calc, instantiated once.

Verification
REQ-038 Mode 0, count_p=23'h000123, capture at cycle 10 -> fifo_wr_en at cycle 13 with fifo_data=24'h000123.
REQ-039 Mode 1, count_p=100, count_m=300 -> fifo_data=24'hFFFF38 (-200); with MEAS_SEQ_TAG_EN, first write tag=0 and fifo_data=24'h3FFF38.
REQ-040 fifo_full=1 through WRITE -> no fifo_wr_en and drop_cnt=1; 300 such drops -> drop_cnt=255.
REQ-041 Second capture one cycle after the first -> only one write and drop_cnt=1.
REQ-042 flush in CALC -> no write, busy=0 next cycle, drop_cnt=0; rst_sync in LATCH -> all REQ-029 values and no write.
REQ-043 MEAS_SEQ_TAG_EN, mode 0, count_p=23'h7FFFFF -> fifo_data[21:0]=22'h3FFFFF; tags over five writes -> 0,1,2,3,0.

Source files
------------

// File: rtl/meas_pkg.sv
// Shared types and constants for the measurement word writer.
// Saturation limits apply only when MEAS_SEQ_TAG_EN is defined.
package meas_pkg;

  localparam int CNT_W_DEF  = 23;
  localparam int WORD_W_DEF = 24;
  localparam int TAG_W      = 2;
  localparam int SAT_W      = WORD_W_DEF - TAG_W;

  // Limits of the tagged payload: unsigned for direct counts, signed for differences
  localparam int SAT_U_MAX = (1 << SAT_W) - 1;
  localparam int SAT_S_MAX = (1 << (SAT_W - 1)) - 1;
  localparam int SAT_S_MIN = -(1 << (SAT_W - 1));

  localparam logic [7:0] DROP_MAX = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_CALC  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/meas_word_calc.sv
// Combinational result for one gate window: direct count or p-m difference.
// With MEAS_SEQ_TAG_EN the result is clamped into the low payload bits, tag bits left zero.
module meas_word_calc
  import meas_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic [CNT_W-1:0]  count_p,
  input  logic [CNT_W-1:0]  count_m,
  input  logic              mode,
  output logic [WORD_W-1:0] result
);

  logic [WORD_W-1:0] raw;

  // One extra bit of headroom makes the difference exact in two's complement
  always_comb begin
    raw = {1'b0, count_p};
    if (mode) begin
      raw = {1'b0, count_p} - {1'b0, count_m};
    end
  end

`ifdef MEAS_SEQ_TAG_EN
  localparam logic signed [WORD_W-1:0] S_HI = WORD_W'(SAT_S_MAX);
  localparam logic signed [WORD_W-1:0] S_LO = WORD_W'(SAT_S_MIN);
  localparam logic        [WORD_W-1:0] U_HI = WORD_W'(SAT_U_MAX);

  logic [WORD_W-1:0] sat;

  always_comb begin
    sat = raw;
    if (!mode) begin
      if (raw > U_HI) sat = U_HI;
    end else if ($signed(raw) > S_HI) begin
      sat = S_HI;
    end else if ($signed(raw) < S_LO) begin
      sat = S_LO;
    end
    result = sat & U_HI;
  end
`else
  assign result = raw;
`endif

endmodule

// File: rtl/meas_word_writer.sv
// Turns each counter capture into one FIFO word three cycles later, counting lost samples.
// Optional MEAS_SEQ_TAG_EN adds a 2-bit write sequence tag in the top word bits.
module meas_word_writer
  import meas_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk_12mhz,
  input  logic              rst_sync,
  input  logic              capture,
  input  logic [CNT_W-1:0]  count_p,
  input  logic [CNT_W-1:0]  count_m,
  input  logic              count_mode,
  input  logic              flush,
  input  logic              fifo_full,
  output logic [WORD_W-1:0] fifo_data,
  output logic              fifo_wr_en,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  p_q, p_d, m_q, m_d;
  logic              mode_q, mode_d;
  logic [WORD_W-1:0] res_q, res_d, last_q, last_d;
  logic [WORD_W-1:0] calc_res, word;
  logic [7:0]        drop_q, drop_d;
  logic [1:0]        drop_inc;
  logic [8:0]        drop_sum;
  logic              wr_en;
`ifdef MEAS_SEQ_TAG_EN
  logic [TAG_W-1:0]  tag_q, tag_d;
`endif

  meas_word_calc #(
    .CNT_W (CNT_W),
    .WORD_W(WORD_W)
  ) u_calc (
    .count_p(p_q),
    .count_m(m_q),
    .mode   (mode_q),
    .result (calc_res)
  );

`ifdef MEAS_SEQ_TAG_EN
  assign word = res_q | {tag_q, {(WORD_W - TAG_W){1'b0}}};
`else
  assign word = res_q;
`endif

  // Handshake: fifo_wr_en is a single-cycle strobe in WRITE when the FIFO is not full;
  // fifo_data is valid in that cycle and otherwise holds the last written word.
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    m_d      = m_q;
    mode_d   = mode_q;
    res_d    = res_q;
    last_d   = last_q;
    drop_d   = drop_q;
    drop_inc = 2'd0;
    drop_sum = 9'd0;
    wr_en    = 1'b0;
`ifdef MEAS_SEQ_TAG_EN
    tag_d    = tag_q;
`endif
    if (flush) begin
      state_d = ST_IDLE;
      drop_d  = 8'd0;
`ifdef MEAS_SEQ_TAG_EN
      tag_d   = '0;
`endif
    end else begin
      if (capture && state_q != ST_IDLE) drop_inc = 2'd1;
      case (state_q)
        ST_IDLE: begin
          if (capture) begin
            p_d     = count_p;
            m_d     = count_m;
            mode_d  = count_mode;
            state_d = ST_LATCH;
          end
        end
        ST_LATCH: state_d = ST_CALC;
        ST_CALC: begin
          res_d   = calc_res;
          state_d = ST_WRITE;
        end
        ST_WRITE: begin
          state_d = ST_IDLE;
          if (fifo_full) drop_inc = drop_inc + 2'd1;
          else           wr_en    = !rst_sync;
        end
        default: state_d = ST_IDLE;
      endcase
      drop_sum = {1'b0, drop_q} + {7'd0, drop_inc};
      drop_d   = drop_sum[8] ? DROP_MAX : drop_sum[7:0];
      if (wr_en) begin
        last_d = word;
`ifdef MEAS_SEQ_TAG_EN
        tag_d  = tag_q + TAG_W'(1);
`endif
      end
    end
  end

  always_ff @(posedge clk_12mhz) begin
    if (rst_sync) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      m_q     <= '0;
      mode_q  <= 1'b0;
      res_q   <= '0;
      last_q  <= '0;
      drop_q  <= 8'd0;
`ifdef MEAS_SEQ_TAG_EN
      tag_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      mode_q  <= mode_d;
      res_q   <= res_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
`ifdef MEAS_SEQ_TAG_EN
      tag_q   <= tag_d;
`endif
    end
  end

  assign fifo_wr_en = wr_en;
  assign fifo_data  = wr_en ? word : last_q;
  assign busy       = (state_q != ST_IDLE);
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_meas_word_writer.sv
// Bench for meas_word_writer: directed scenarios plus random traffic against a sample-level model.
module tb_meas_word_writer;

  logic        clk_12mhz;
  logic        rst_sync, capture, count_mode, flush, fifo_full;
  logic [22:0] count_p, count_m;
  logic [23:0] fifo_data;
  logic        fifo_wr_en, busy;
  logic [7:0]  drop_cnt;

  meas_word_writer dut (
    .clk_12mhz (clk_12mhz),
    .rst_sync  (rst_sync),
    .capture   (capture),
    .count_p   (count_p),
    .count_m   (count_m),
    .count_mode(count_mode),
    .flush     (flush),
    .fifo_full (fifo_full),
    .fifo_data (fifo_data),
    .fifo_wr_en(fifo_wr_en),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk_12mhz = 1'b0;
  always #5 clk_12mhz = ~clk_12mhz;

  // ---------------- model state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  logic [23:0] exp_q[$];
  int          exp_cyc_q[$];
  bit          pend_v = 1'b0;
  int          pend_at = 0;
  int          pend_p, pend_m;
  bit          pend_md;
  int          m_drop = 0;
  int          m_tag = 0;
  logic [23:0] m_last = '0;
  bit          exp_busy = 1'b0;
  logic [7:0]  exp_drop = '0;
  logic [23:0] exp_last = '0;

  function automatic logic [23:0] model_word(input int p, input int m, input bit md, input int tag);
    longint v;
    v = md ? longint'(p) - longint'(m) : longint'(p);
`ifdef MEAS_SEQ_TAG_EN
    if (!md && v > 4194303) v = 4194303;
    if (md && v > 2097151) v = 2097151;
    if (md && v < -2097152) v = -2097152;
    return 24'((longint'(tag) << 22) | (v & 64'h3FFFFF));
`else
    return 24'(v & 64'hFFFFFF);
`endif
  endfunction

  // One clock cycle: drive inputs, then advance the sample-level model for this cycle
  task automatic step(input bit cap, input int p, input int m, input bit md,
                      input bit fu, input bit fl, input bit rs);
    int  inc;
    bit  was_busy;
    logic [23:0] w;
    @(posedge clk_12mhz);
    #1;
    cyc++;
    capture    = cap;
    count_p    = 23'(p);
    count_m    = 23'(m);
    count_mode = md;
    fifo_full  = fu;
    flush      = fl;
    rst_sync   = rs;
    was_busy   = pend_v && (cyc > pend_at - 3);
    exp_busy   = was_busy;
    exp_drop   = 8'(m_drop);
    exp_last   = m_last;
    if (rs) begin
      pend_v = 1'b0; m_drop = 0; m_tag = 0; m_last = '0;
    end else if (fl) begin
      pend_v = 1'b0; m_drop = 0; m_tag = 0;
    end else begin
      inc = 0;
      if (pend_v && cyc == pend_at) begin
        pend_v = 1'b0;
        if (fu) inc++;
        else begin
          w = model_word(pend_p, pend_m, pend_md, m_tag);
          exp_q.push_back(w);
          exp_cyc_q.push_back(cyc);
          m_last = w;
          m_tag  = (m_tag + 1) % 4;
        end
      end
      if (cap) begin
        if (was_busy) inc++;
        else begin
          pend_v = 1'b1; pend_at = cyc + 3;
          pend_p = p; pend_m = m; pend_md = md;
        end
      end
      m_drop = (m_drop + inc > 255) ? 255 : m_drop + inc;
    end
  endtask

  task automatic idle(input int n, input bit fu);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, fu, 1'b0, 1'b0);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk_12mhz) begin
    if (chk_en) begin
      if (fifo_wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(fifo_data), 32'hFFFF_FFFF);
        end else begin
          chk("wr_data", 32'(fifo_data), 32'(exp_q.pop_front()));
          chk("wr_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
        end
      end else begin
        if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
          chk("missing_write", 32'(fifo_wr_en), 32'd1);
          void'(exp_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end
        chk("hold_data", 32'(fifo_data), 32'(exp_last));
      end
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_sync = 1'b1; capture = 1'b0; count_p = '0; count_m = '0;
    count_mode = 1'b0; flush = 1'b0; fifo_full = 1'b0;
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(7, 1'b0);
    // capture lands in cycle 10, write expected in cycle 13
    step(1'b1, 'h000123, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0);
    step(1'b1, 100, 300, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0);
    // FIFO full through WRITE
    step(1'b1, 55, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);
    // back-to-back captures: second one is a drop
    step(1'b1, 77, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 78, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0);
    // flush while in CALC
    step(1'b1, 99, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4, 1'b0);
    // reset while in LATCH
    step(1'b1, 123, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4, 1'b0);
    // saturate drop counter, then flush it back to zero
    for (int i = 0; i < 300; i++) step(1'b1, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);
    step(1'b1, 6, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4, 1'b0);
    // five writes of the maximum count: saturation and tag wrap
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 'h7FFFFF, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3, 1'b0);
    end
    step(1'b1, 0, 'h7FFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 3, int'($urandom_range(0, 'h7FFFFF)),
           int'($urandom_range(0, 'h7FFFFF)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 99) == 0);
    end
    idle(6, 1'b0);
    @(posedge clk_12mhz);
    #1;
    chk_en = 1'b0;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
